// File: rtl/core_pkg.sv
// Shared core definitions: word width, canonical NOP, fetch FSM states and a PC alignment helper.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OOB  = 2'd2
  } fetch_state_t;

  // Clear the two low address bits: fetch is word aligned only.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN - 2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch front end bus: instruction-memory read port, redirect input and decode handshake.
interface inst_fetch_if;
  import core_pkg::*;

  logic            fetch_en;
  logic [XLEN-1:0] instaddr;
  logic [XLEN-1:0] inst_in;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic            fetch_oob;

  // Fetch unit side.
  modport master (
    input  fetch_en,
    input  inst_in,
    input  redirect_valid,
    input  redirect_target,
    input  out_ready,
    output instaddr,
    output out_valid,
    output out_inst,
    output out_pc,
    output fetch_oob
  );

  // Memory / decode / branch-resolution side.
  modport slave (
    output fetch_en,
    output inst_in,
    output redirect_valid,
    output redirect_target,
    output out_ready,
    input  instaddr,
    input  out_valid,
    input  out_inst,
    input  out_pc,
    input  fetch_oob
  );

endinterface

// File: rtl/fetch_buf.sv
// Small synchronous FIFO holding {pc, inst} entries between fetch and decode.
// Push and pop may coincide at any fill level; flush empties it on the next edge.
module fetch_buf #(
  parameter int unsigned  BUF_DEPTH = 2,
  parameter int unsigned  WIDTH     = 64,
  localparam int unsigned PW        = $clog2(BUF_DEPTH),
  localparam int unsigned CW        = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Entry storage: written at the tail on push, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push && !i_flush) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head reads as zero while empty so decode never sees stale data.
  assign o_head  = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC register, fetch FSM, push/redirect control and the
// fetch buffer toward decode. Memory returns the word for instaddr in the same cycle.
module inst_fetch
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_WORDS = 401,
  parameter int unsigned     BUF_DEPTH  = 2
) (
  input logic          clk,
  input logic          rst_n,
  inst_fetch_if.master bus
);

  localparam int unsigned     CW       = $clog2(BUF_DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_WORDS * 4);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_oob;

  logic [CW-1:0]     w_count;
  logic [2*XLEN-1:0] w_head;
  logic              w_out_valid;
  logic              w_pop;
  logic              w_room;
  logic              w_push;
  logic [XLEN-1:0]   w_tgt;
  logic              w_tgt_ok;
  logic [XLEN-1:0]   w_pc_inc;
  logic              w_at_end;

  // A redirect hides the head immediately; the flushed entries are never delivered.
  assign w_out_valid = (w_count != '0) & ~bus.redirect_valid;
  assign w_pop       = w_out_valid & bus.out_ready;
  // A same-cycle pop frees the slot, so a full buffer can still accept.
  assign w_room      = (w_count < CW'(BUF_DEPTH)) | w_pop;
  assign w_push      = (r_state == RUN) & bus.fetch_en & ~bus.redirect_valid & w_room;

  assign w_tgt    = align_word(bus.redirect_target);
  assign w_tgt_ok = w_tgt < PC_LIMIT;
  assign w_pc_inc = r_pc + XLEN'(4);
  assign w_at_end = w_pc_inc >= PC_LIMIT;

  fetch_buf #(
    .BUF_DEPTH (BUF_DEPTH),
    .WIDTH     (2 * XLEN)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_data  ({r_pc, bus.inst_in}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // PC: redirect wins, otherwise advance only when the fetched word was queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      r_pc <= w_tgt;
    end else if (w_push) begin
      r_pc <= w_pc_inc;
    end
  end

  // Fetch FSM with fetch_oob registered alongside the state it mirrors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_oob   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.fetch_en) r_state <= RUN;
        end
        RUN: begin
          if (bus.redirect_valid) begin
            if (!w_tgt_ok) begin
              r_state <= OOB;
              r_oob   <= 1'b1;
            end else if (!bus.fetch_en) begin
              r_state <= IDLE;
            end
          end else if (!bus.fetch_en) begin
            r_state <= IDLE;
          end else if (w_push && w_at_end) begin
            r_state <= OOB;
            r_oob   <= 1'b1;
          end
        end
        OOB: begin
          if (bus.redirect_valid && w_tgt_ok) begin
            r_state <= bus.fetch_en ? RUN : IDLE;
            r_oob   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_oob   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instaddr  = r_pc;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = w_head[2*XLEN-1:XLEN];
  assign bus.out_inst  = w_head[XLEN-1:0];
  assign bus.fetch_oob = r_oob;

endmodule
